// File: rtl/seven_seg_scanner.sv
// Two-digit common-anode scanner: capture, guard/show timing, LZB, decode.
// Optional blink support is built when SEVEN_SEG_SCANNER_BLINK_EN is defined.
module seven_seg_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 500
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_lo,
  input  logic [3:0] digit_hi,
  input  logic       load,
  input  logic       lzb,
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  input  logic       blink,
`endif
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV + 1);

  typedef enum logic [1:0] {
    GUARD_LO,
    SHOW_LO,
    GUARD_HI,
    SHOW_HI
  } state_e;

  state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] shadow_lo_q, shadow_lo_d;
  logic [3:0] shadow_hi_q, shadow_hi_d;
  logic [3:0] disp_lo_q, disp_lo_d;
  logic [3:0] disp_hi_q, disp_hi_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;
  logic       tick_q, tick_d;
  logic       last_cyc;
  logic       force_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    if (state_q == GUARD_LO || state_q == GUARD_HI)
      last_cyc = (cnt_q == CW'(GUARD_CYC - 1));
    else
      last_cyc = (cnt_q == CW'(SCAN_DIV - 1));
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (last_cyc) begin
      cnt_d = '0;
      unique case (state_q)
        GUARD_LO: state_d = SHOW_LO;
        SHOW_LO:  state_d = GUARD_HI;
        GUARD_HI: state_d = SHOW_HI;
        SHOW_HI:  state_d = GUARD_LO;
      endcase
    end
    shadow_lo_d = load ? digit_lo : shadow_lo_q;
    shadow_hi_d = load ? digit_hi : shadow_hi_q;
    // Display latches only at slot boundaries so a lit digit never changes.
    disp_lo_d = (last_cyc && state_q == SHOW_HI) ? shadow_lo_q : disp_lo_q;
    disp_hi_d = (last_cyc && state_q == SHOW_LO) ? shadow_hi_q : disp_hi_q;
    tick_d = last_cyc && (state_q == SHOW_HI);
    an_d  = 2'b11;
    seg_d = 7'h7F;
    case (state_q)
      SHOW_LO: begin
        if (!force_blank) begin
          an_d  = 2'b10;
          seg_d = decode(disp_lo_q);
        end
      end
      SHOW_HI: begin
        if (!force_blank && !(lzb && disp_hi_q == 4'd0)) begin
          an_d  = 2'b01;
          seg_d = decode(disp_hi_q);
        end
      end
      default: ;
    endcase
  end

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  assign force_blank = blink && phase_q;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick_d) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign force_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GUARD_LO;
      cnt_q       <= '0;
      shadow_lo_q <= '0;
      shadow_hi_q <= '0;
      disp_lo_q   <= '0;
      disp_hi_q   <= '0;
      seg_q       <= 7'h7F;
      an_q        <= 2'b11;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_lo_q <= shadow_lo_d;
      shadow_hi_q <= shadow_hi_d;
      disp_lo_q   <= disp_lo_d;
      disp_hi_q   <= disp_hi_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: frame-position model plus literal pin checks.
// Small timing parameters keep frames at 10 cycles.
module tb_seven_seg_scanner;

  localparam int S = 4;
  localparam int G = 1;
  localparam int F = 2 * (G + S);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_lo, digit_hi;
  logic       load, lzb;
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  logic       blink;
`endif
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  seven_seg_scanner #(
    .SCAN_DIV(S),
    .GUARD_CYC(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_lo(digit_lo),
    .digit_hi(digit_hi),
    .load(load),
    .lzb(lzb),
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    .blink(blink),
`endif
    .seg_n(seg_n),
    .an_n(an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 'h%0h, want 'h%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (d > 4'd9) return 7'b0111111;
    return tbl[d];
  endfunction

  // Model: position in frame from edge count since reset release.
  int         t;
  int         p;
  logic [3:0] m_slo, m_shi, m_dlo, m_dhi;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic       exp_ft;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0;
        m_slo = 0; m_shi = 0; m_dlo = 0; m_dhi = 0;
        exp_seg = 7'h7F; exp_an = 2'b11; exp_ft = 1'b0;
      end else begin
        p = t % F;
        exp_seg = 7'h7F; exp_an = 2'b11;
        if (p >= G && p < G + S) begin
          exp_an = 2'b10; exp_seg = glyph(m_dlo);
        end else if (p >= 2 * G + S && !(lzb && m_dhi == 0)) begin
          exp_an = 2'b01; exp_seg = glyph(m_dhi);
        end
        exp_ft = (p == F - 1);
        t++;
        if (t % F == 0) m_dlo = m_slo;
        if (t % F == G + S) m_dhi = m_shi;
        if (load) begin
          m_slo = digit_lo; m_shi = digit_hi;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("seg_n", seg_n, exp_seg);
      check("an_n", an_n, exp_an);
      check("frame_tick", frame_tick, exp_ft);
    end
  end

  task automatic load_digits(input logic [3:0] lo, input logic [3:0] hi);
    digit_lo = lo; digit_hi = hi; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int i = 0; i < 3 * F && !got; i++) begin
      @(negedge clk);
      got = frame_tick;
    end
    check("tick_wait", got, 1);
  endtask

  // Called with pins showing the last SHOW_HI cycle; walks one full frame.
  task automatic frame_lit(input logic [6:0] lo_seg, input logic [1:0] hi_an,
                           input logic [6:0] hi_seg);
    @(negedge clk);
    check("lit_guard_lo_an", an_n, 2'b11);
    @(negedge clk);
    check("lit_lo_an", an_n, 2'b10);
    check("lit_lo_seg", seg_n, lo_seg);
    repeat (S - 1) @(negedge clk);
    @(negedge clk);
    check("lit_guard_hi_seg", seg_n, 7'h7F);
    @(negedge clk);
    check("lit_hi_an", an_n, hi_an);
    check("lit_hi_seg", seg_n, hi_seg);
    repeat (S - 1) @(negedge clk);
    check("lit_tick", frame_tick, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; digit_lo = 0; digit_hi = 0; load = 0; lzb = 0;
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_an", an_n, 2'b11);
    check("rst_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    load_digits(4'd5, 4'd1);
    wait_tick();
    wait_tick();
    frame_lit(7'b0010010, 2'b01, 7'b1111001);
    frame_lit(7'b0010010, 2'b01, 7'b1111001);

    // Load lo=3 while lo=5 is lit: current slot must keep showing 5.
    @(negedge clk);
    @(negedge clk);
    digit_lo = 4'd3; digit_hi = 4'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("midslot_keep0", seg_n, 7'b0010010);
    @(negedge clk);
    check("midslot_keep1", seg_n, 7'b0010010);
    wait_tick();
    frame_lit(7'b0110000, 2'b01, 7'b1111001);

    lzb = 1'b1;
    load_digits(4'd7, 4'd0);
    wait_tick();
    wait_tick();
    frame_lit(7'b1111000, 2'b11, 7'h7F);
    lzb = 1'b0;
    frame_lit(7'b1111000, 2'b01, 7'b1000000);

    load_digits(4'd12, 4'd0);
    wait_tick();
    wait_tick();
    frame_lit(7'b0111111, 2'b01, 7'b1000000);

    // Async reset in the middle of SHOW_HI.
    load_digits(4'd8, 4'd4);
    wait_tick();
    wait_tick();
    repeat (7) @(negedge clk);
    check("pre_rst_hi_an", an_n, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg_n, 7'h7F);
    check("async_rst_an", an_n, 2'b11);
    check("async_rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_guard", an_n, 2'b11);
    @(negedge clk);
    check("post_rst_lo_an", an_n, 2'b10);
    check("post_rst_lo_seg", seg_n, 7'b1000000);
    wait_tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
